// File: rtl/lane_packer_if.sv
// ============================================================================
// Module   : lane_packer_if
// Brief    : Lane-in / packed-word-out handshake bundle for lane_packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lane_packer_if #(
    parameter int LANE_W = 8,
    parameter int LANES  = 4,
    parameter int CNT_W  = $clog2(LANES + 1)
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANE_W-1:0]       in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*LANE_W-1:0] out_data;
    logic [LANES-1:0]        out_mask;
    logic [CNT_W-1:0]        out_count;

    // Producer/consumer side that drives lanes in and takes words out
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_mask, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_mask, out_count
    );
endinterface

`default_nettype wire

// File: rtl/lane_packer.sv
// ============================================================================
// Module   : lane_packer
// Brief    : Gathers LANE_W-bit lanes into a LANES-wide packed bus word with
//            early close on in_last and a single output holding register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_packer #(
    parameter int LANE_W = 8,
    parameter int LANES  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    lane_packer_if.slave bus
);
    localparam int c_CNT_W  = $clog2(LANES + 1);
    localparam int c_IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_WORD_W = LANES * LANE_W;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(LANES - 1);
    localparam logic [LANES-1:0]   c_ALL_LANES = '1;

    logic [c_WORD_W-1:0] r_acc_data;
    logic [c_IDX_W-1:0]  r_acc_idx;
    logic                r_out_valid;
    logic [c_WORD_W-1:0] r_out_data;
    logic [LANES-1:0]    r_out_mask;
    logic [c_CNT_W-1:0]  r_out_count;

    logic                w_out_free;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_complete;
    logic [c_WORD_W-1:0] w_acc_merged;
    logic [LANES-1:0]    w_fill_mask;

    assign w_out_free = !r_out_valid || bus.out_ready;
    // Only the beat that would close a word has to wait for the output slot
    assign w_in_ready = w_out_free || ((r_acc_idx != c_LAST_IDX) && !bus.in_last);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_complete = (r_acc_idx == c_LAST_IDX) || bus.in_last;

    // Accumulator with the incoming lane dropped into slot r_acc_idx
    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            localparam logic [c_IDX_W-1:0] c_K = c_IDX_W'(k);
            assign w_acc_merged[k*LANE_W +: LANE_W] =
                (r_acc_idx == c_K) ? bus.in_data : r_acc_data[k*LANE_W +: LANE_W];
        end
    endgenerate

    // Thermometer of the low r_acc_idx+1 lanes
    assign w_fill_mask = c_ALL_LANES >> (c_LAST_IDX - r_acc_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_data  <= '0;
            r_acc_idx   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
            r_out_count <= '0;
        end else begin
            if (w_accept) begin
                if (w_complete) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_acc_merged;
                    r_out_mask  <= w_fill_mask;
                    r_out_count <= c_CNT_W'(r_acc_idx) + c_CNT_W'(1);
                    r_acc_data  <= '0;
                    r_acc_idx   <= '0;
                end else begin
                    r_acc_data  <= w_acc_merged;
                    r_acc_idx   <= r_acc_idx + c_IDX_W'(1);
                end
            end
            // A drain coinciding with a new word keeps out_valid high
            if (r_out_valid && bus.out_ready && !(w_accept && w_complete)) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_mask  = r_out_mask;
    assign bus.out_count = r_out_count;

endmodule

`default_nettype wire

// File: doc/lane_packer.md
# lane_packer

Parametrised, clocked successor to the register-file bus packing helpers. It gathers a stream of `LANE_W`-bit lane values into one packed `LANES*LANE_W`-bit bus word. Lane k occupies bits `[(k+1)*LANE_W-1 : k*LANE_W]`, with lane 0 at the LSBs. Words can close early on `in_last`, and both sides use valid/ready handshakes with one output holding register. It sits between byte-serial producers (load/store path, debug port) and the register-file write bus.

## Interface

Parameters:
- `LANE_W`, 8, width of one lane; legal values ≥1.
- `LANES`, 4, lanes per packed word; legal values ≥1.
- `CNT_W`, `$clog2(LANES+1)`, derived width of `out_count`; not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer offers `in_data`.
- `in_ready`  out  1  block accepts the offered lane this cycle.
- `in_data`  in  `LANE_W`  lane value.
- `in_last`  in  1  this lane closes the current word; qualified by `in_valid`.
- `out_valid`  out  1  packed word available.
- `out_ready`  in  1  consumer takes the word.
- `out_data`  out  `LANES*LANE_W`  packed word.
- `out_mask`  out  `LANES`  bit k = 1 when lane k holds data.
- `out_count`  out  `CNT_W`  number of filled lanes, 1..LANES.

## Operation

State:
- Accumulator `acc_data` (`LANES*LANE_W` bits).
- Fill index `acc_idx` (0..LANES-1; the next lane to write).
- Output register: `out_valid`, `out_data`, `out_mask`, `out_count`.

Rules:
- `out_free = !out_valid || out_ready`.
- `in_ready = out_free || (acc_idx != LANES-1 && !in_last)`. `in_ready` may depend combinationally on `in_valid`/`in_last`. It never depends on `in_data`.
- Accept occurs when `in_valid && in_ready`. `in_data` is written to lane `acc_idx` of the accumulator.
- Completion beat: an accepted beat with `acc_idx == LANES-1` or `in_last == 1`. On that beat:
  - The accumulator, including the new lane, is loaded into `out_data`.
  - Unfilled lanes are driven as zero.
  - `out_count = acc_idx+1`.
  - `out_mask` gets the low `acc_idx+1` bits set.
  - `out_valid` is set to 1.
  - `acc_data` clears to 0 and `acc_idx` resets to 0.
- Non-completion accept: `acc_idx` increments. The output register is untouched.
- Output drain: when `out_valid && out_ready` and there is no completion beat in the same cycle, `out_valid` goes to 0 next cycle. `out_data`/`out_mask`/`out_count` hold their last values.
- Drain and a completion beat in the same cycle: the new word replaces the old one and `out_valid` stays 1. There is no bubble.
- While `out_valid && !out_ready`, the output registers are stable.
- `LANES == 1`: every accepted beat is a completion beat, and `in_ready = out_free`.
- `in_last` with `in_valid == 0` is ignored.
- No lane is ever dropped or duplicated.

Reset (asynchronous, `rst_n` low):
- `out_valid=0`, `out_data=0`, `out_mask=0`, `out_count=0`, `acc_data=0`, `acc_idx=0`.
- A partial word in the accumulator is discarded.
- After reset, `in_ready=1`.
- Reset release is synchronous to `clk` at the integration level; no internal synchroniser.

## Timing

- Latency: a completion beat at edge N gives `out_valid=1` with the new word after edge N.
- Throughput: one lane per cycle sustained while `out_ready=1`. A full word appears every LANES cycles (every cycle when `LANES=1`).
- Backpressure: the accumulator keeps filling up to lane LANES-2. The completion beat stalls (`in_ready=0`) until `out_free`.
- Combinational paths:
  - `out_ready` → `in_ready`.
  - `in_last`/`in_valid` → `in_ready`.
  - There is no path from inputs to `out_*`.

## Test plan

Parameters for all scenarios: `LANE_W=8`, `LANES=4`.

1. Reset: hold `rst_n=0` mid-stream with arbitrary inputs → `out_valid=0`, `out_data=0`, `out_mask=0`, `out_count=0` immediately (asynchronous). After release, `in_ready=1`.
2. Full word: send 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `out_ready=1` → one cycle after the 4th accept: `out_valid=1`, `out_data=0x44332211`, `out_mask=4'b1111`, `out_count=4`. Then 0x55..0x88 back-to-back → `0x88776655` exactly 4 cycles later, no bubble.
3. Early close: send 0xAA, then 0xBB with `in_last=1` → `out_data=0x0000BBAA`, `out_mask=4'b0011`, `out_count=2`. A following 0x5A with `in_last=1` → `0x0000005A`, `out_mask=4'b0001`, `out_count=1`.
4. Backpressure: with `0x44332211` held and `out_ready=0`:
   - Send 0x55, 0x66, 0x77 → all accepted.
   - 0x88 → `in_ready=0`; the output stays `0x44332211`.
   - Raise `out_ready` → 0x88 is accepted the same cycle, and the next cycle shows `out_data=0x88776655` with `out_valid` continuously 1.
5. Reset mid-word: accept 0x01, 0x02, assert `rst_n=0` for one cycle, then send 0xA1..0xA4 → `out_data=0xA4A3A2A1`; no trace of 0x01/0x02.
6. `LANES=1` build: send 0x3C, 0xC3 back-to-back with `out_ready=1` → two words, `0x3C` then `0xC3`, on consecutive cycles, each with `out_mask=1`, `out_count=1`.
